// File: rtl/mul_seq_32.sv
// Sequential unsigned 32x32->64 shift-add multiplier built around a ripple adder_32.
// Latency: done pulses 32 cycles after the accepted start edge; start is ignored while busy.
// Backpressure: none; the controller must wait for done before the next start is taken.

module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c,
    input  logic        control,
    output logic [31:0] sum,
    output logic        cy,
    output logic        overflow
);
    // control=1 turns the adder into a subtractor (b inverted, c supplies the +1)
    always_comb begin
        logic carry;
        logic carry_msb;
        logic bb;
        carry     = c;
        carry_msb = 1'b0;
        sum       = '0;
        for (int i = 0; i < 32; i++) begin
            bb     = b[i] ^ control;
            sum[i] = a[i] ^ bb ^ carry;
            if (i == 31) carry_msb = carry;
            carry  = (a[i] & bb) | (a[i] & carry) | (bb & carry);
        end
        cy       = carry;
        overflow = carry ^ carry_msb;
    end
endmodule

module mul_seq_32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 hi_nz
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  acc_hi;
    logic [WIDTH-1:0]  acc_lo;
    logic [4:0]        cnt;

    logic [WIDTH-1:0]  addend;
    logic [WIDTH-1:0]  sum;
    logic              cy;
    logic              ovf_unused;
    logic              last;

    assign addend = acc_lo[0] ? mcand : '0;
    assign last   = (cnt == 5'd31);

    adder_32 u_adder (
        .a        (acc_hi),
        .b        (addend),
        .c        (1'b0),
        .control  (1'b0),
        .sum      (sum),
        .cy       (cy),
        .overflow (ovf_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
            hi_nz   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= a;
                    acc_lo <= b;
                    acc_hi <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    // {cy,sum} is 33 bits; the shift drops nothing but the consumed multiplier bit
                    acc_hi <= {cy, sum[WIDTH-1:1]};
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + 5'd1;
                    if (last) begin
                        product <= {cy, sum, acc_lo[WIDTH-1:1]};
                        hi_nz   <= cy | (|sum[WIDTH-1:1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_32.sv
// Directed-vector and random bench for mul_seq_32.
module tb_mul_seq_32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, hi_nz;
    logic [63:0] product;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        logic        h;
    } vec_t;

    vec_t vecs[10];

    mul_seq_32 #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .hi_nz   (hi_nz)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Returns at the negedge right after the accepting edge.
    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts negedges since the accepting edge; stops on done or budget.
    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = 0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (done && busy) bcnt++;
    endtask

    initial begin
        int lat, bcnt;
        logic saw_done;
        logic [63:0] exp;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1'b1};
        vecs[2] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, 1'b1};
        vecs[3] = '{32'd0,          32'h1234_5678,  64'h0000_0000_0000_0000, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE, 1'b1};
        vecs[6] = '{32'h0000_FFFF,  32'h0000_FFFF,  64'h0000_0000_FFFE_0001, 1'b0};
        vecs[7] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b1};
        vecs[8] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 1'b1};
        vecs[9] = '{32'd1,          32'd1,          64'h0000_0000_0000_0001, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_hi_nz", 64'(hi_nz), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(0, lat, bcnt);
            check($sformatf("vec%0d_product", i), product, vecs[i].p);
            check($sformatf("vec%0d_hi_nz", i), 64'(hi_nz), 64'(vecs[i].h));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd33);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_busy_fall", i), 64'(busy), 64'd0);
        end

        // start held high; operand changes during RUN/DONE must not leak in
        @(negedge clk);
        a = 32'd3;
        b = 32'd5;
        start = 1'b1;
        repeat (10) @(negedge clk);
        a = 32'd7;
        b = 32'd9;
        wait_done(9, lat, bcnt);
        check("held_first_product", product, 64'd15);
        check("held_first_latency", 64'(lat), 64'd32);
        @(negedge clk);
        check("held_idle_gap", 64'(busy), 64'd0);
        @(negedge clk);
        check("held_second_accept", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(0, lat, bcnt);
        check("held_second_product", product, 64'd63);
        check("held_second_latency", 64'(lat), 64'd32);

        // product holds across accept; async reset mid-run clears everything
        launch(32'd9, 32'd9);
        repeat (5) @(negedge clk);
        check("hold_product_in_run", product, 64'd63);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_product", product, 64'd0);
        check("arst_hi_nz", 64'(hi_nz), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("arst_no_done", 64'(saw_done), 64'd0);
        launch(32'd6, 32'd7);
        wait_done(0, lat, bcnt);
        check("post_rst_product", product, 64'd42);

        // start already high when reset releases
        @(negedge clk);
        rst_n = 1'b0;
        a = 32'd2;
        b = 32'd3;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_release_accept", 64'(busy), 64'd1);
        wait_done(0, lat, bcnt);
        check("rst_release_product", product, 64'd6);
        check("rst_release_latency", 64'(lat), 64'd32);

        for (int i = 0; i < 32; i++) begin
            logic [31:0] bb;
            logic [31:0] aa;
            bb = 32'd1 << i;
            aa = 32'hDEAD_BEEF;
            launch(aa, bb);
            wait_done(0, lat, bcnt);
            exp = 64'(aa) << i;
            check($sformatf("onehot%0d_product", i), product, exp);
            check($sformatf("onehot%0d_hi_nz", i), 64'(hi_nz), 64'(|exp[63:32]));
        end

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] aa, bb;
            aa = $urandom;
            bb = $urandom;
            if (i % 10 == 0) aa = aa >> (i % 32);
            launch(aa, bb);
            wait_done(0, lat, bcnt);
            exp = {32'd0, aa} * {32'd0, bb};
            check($sformatf("rand%0d_product", i), product, exp);
            check($sformatf("rand%0d_hi_nz", i), 64'(hi_nz), 64'(|exp[63:32]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
